full_subtractor_unit: RTL and testbench

Single-bit (parameterisable to N-bit ripple) binary full subtractor computing x − y − bin, producing difference d and borrow-out bout. Combinational outputs serve datapath logic directly; a one-stage registered copy with a valid flag serves clocked consumers. Leaf arithmetic cell for the CS220 arithmetic blocks, where it chains into ripple-borrow subtractors.

---
 rtl/full_subtractor_unit.sv | 37 +++
 tb/tb_full_subtractor_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/full_subtractor_unit.sv
// full_subtractor_unit: ripple-borrow x - y - bin with combinational and registered results
module full_subtractor_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic [WIDTH-1:0] d_q,
    output logic             bout_q,
    output logic             out_valid
);
    logic [WIDTH:0] b;
    assign b[0] = bin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d[i]   = x[i] ^ y[i] ^ b[i];
        assign b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b[i]);
    end
    assign bout = b[WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q       <= '0;
            bout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d_q    <= d;
                bout_q <= bout;
            end
        end
    end
endmodule

// File: tb/tb_full_subtractor_unit.sv
// tb_full_subtractor_unit: table-driven vectors plus registered-path sequences
module tb_full_subtractor_unit;
    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       bin;
        logic [3:0] d;
        logic       bout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       x1 = 1'b0, y1 = 1'b0, bin1 = 1'b0;
    logic       d1, bout1, d1_q, bout1_q, ov1;
    logic [3:0] x4 = '0, y4 = '0;
    logic       bin4 = 1'b0;
    logic [3:0] d4, d4_q;
    logic       bout4, bout4_q, ov4;
    int         errors = 0;
    int         checks = 0;
    vec_t       t1 [8];
    vec_t       t4 [6];

    always #5 clk = ~clk;

    full_subtractor_unit #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .bin(bin1), .in_valid(in_valid),
        .d(d1), .bout(bout1), .d_q(d1_q), .bout_q(bout1_q), .out_valid(ov1)
    );

    full_subtractor_unit #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .x(x4), .y(y4), .bin(bin4), .in_valid(in_valid),
        .d(d4), .bout(bout4), .d_q(d4_q), .bout_q(bout4_q), .out_valid(ov4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set1(input logic xv, input logic yv, input logic bv);
        x1 = xv;
        y1 = yv;
        bin1 = bv;
    endtask

    initial begin
        t1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        t1[1] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b1};
        t1[2] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        t1[3] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b0};
        t1[4] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b1};
        t1[5] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
        t1[6] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b0};
        t1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};
        t4[0] = '{4'd3,  4'd5,  1'b1, 4'd13, 1'b1};
        t4[1] = '{4'd9,  4'd4,  1'b0, 4'd5,  1'b0};
        t4[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        t4[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        t4[4] = '{4'd8,  4'd7,  1'b0, 4'd1,  1'b0};
        t4[5] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};

        // combinational sweeps, reset held so the register stage stays idle
        for (int i = 0; i < 8; i++) begin
            set1(t1[i].x[0], t1[i].y[0], t1[i].bin);
            #10;
            chk($sformatf("w1_d[%0d]", i), 32'(d1), 32'(t1[i].d[0]));
            chk($sformatf("w1_bout[%0d]", i), 32'(bout1), 32'(t1[i].bout));
        end
        for (int i = 0; i < 6; i++) begin
            x4 = t4[i].x;
            y4 = t4[i].y;
            bin4 = t4[i].bin;
            #10;
            chk($sformatf("w4_d[%0d]", i), 32'(d4), 32'(t4[i].d));
            chk($sformatf("w4_bout[%0d]", i), 32'(bout4), 32'(t4[i].bout));
        end

        // reset held two cycles with in_valid high
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        set1(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_q", 32'(d1_q), 0);
        chk("rst_bout_q", 32'(bout1_q), 0);
        chk("rst_out_valid", 32'(ov1), 0);
        chk("rst_d_comb", 32'(d1), 1);
        chk("rst_bout_comb", 32'(bout1), 0);

        // single-cycle capture latency and hold
        @(negedge clk);
        rst = 1'b0;
        set1(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_d_q", 32'(d1_q), 0);
        chk("lat_bout_q", 32'(bout1_q), 1);
        chk("lat_out_valid", 32'(ov1), 1);
        set1(1'b1, 1'b0, 1'b0);
        #1;
        chk("midcycle_d_q", 32'(d1_q), 0);
        chk("midcycle_bout_q", 32'(bout1_q), 1);
        @(negedge clk);
        chk("hold_out_valid", 32'(ov1), 0);
        chk("hold_d_q", 32'(d1_q), 0);
        chk("hold_bout_q", 32'(bout1_q), 1);

        // load d_q=1, then reset with in_valid on the same edge
        in_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_d_q", 32'(d1_q), 1);
        rst = 1'b1;
        set1(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("prio_out_valid", 32'(ov1), 0);
        chk("prio_d_q", 32'(d1_q), 0);
        chk("prio_bout_q", 32'(bout1_q), 0);
        rst = 1'b0;
        set1(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_out_valid", 32'(ov1), 1);
        chk("post_rst_d_q", 32'(d1_q), 1);

        // streaming all width-1 vectors back to back
        for (int i = 0; i < 8; i++) begin
            set1(t1[i].x[0], t1[i].y[0], t1[i].bin);
            @(negedge clk);
            chk($sformatf("stream_d_q[%0d]", i), 32'(d1_q), 32'(t1[i].d[0]));
            chk($sformatf("stream_bout_q[%0d]", i), 32'(bout1_q), 32'(t1[i].bout));
            chk($sformatf("stream_out_valid[%0d]", i), 32'(ov1), 1);
        end

        // width-4 registered capture
        x4 = 4'd3;
        y4 = 4'd5;
        bin4 = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("w4_d_q", 32'(d4_q), 13);
        chk("w4_bout_q", 32'(bout4_q), 1);
        chk("w4_out_valid", 32'(ov4), 1);
        @(negedge clk);
        chk("w4_idle_out_valid", 32'(ov4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
